// File: rtl/decoder_nto2n_seq.sv
// Sequenced N-to-2**N decoder: a direct request is held for HOLD_CYCLES cycles, or the block walks every output (scan).
// Scan mode is only built when the DECODER_SCAN_EN macro is defined; otherwise mode is ignored and scan_wrap stays 0.
module decoder_nto2n_seq #(
    parameter int N           = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                sel_valid,
    input  logic [N-1:0]        sel,
    output logic                sel_ready,
    output logic [(2**N)-1:0]   D,
    output logic                D_valid,
    output logic                busy,
    output logic                scan_wrap,
    output logic [1:0]          state_dbg
);

    localparam int W = 2**N;
    localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   d_nx;
    logic           d_valid_nx;
    logic           wrap_nx;
    logic [7:0]     timer, timer_nx;
    logic           mode_eff;

`ifdef DECODER_SCAN_EN
    logic [N-1:0]   idx, idx_nx;
    assign mode_eff = mode;
`else
    logic           unused_mode;
    assign unused_mode = mode;
    assign mode_eff    = 1'b0;
`endif

    // Handshake: a request transfers on a rising edge where sel_valid && sel_ready;
    // sel_ready depends only on the registered state and en/mode, never on sel_valid.
    assign sel_ready = (state == IDLE) && en && !mode_eff;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_nx   = state;
        d_nx       = D;
        d_valid_nx = D_valid;
        wrap_nx    = 1'b0;
        timer_nx   = timer;
`ifdef DECODER_SCAN_EN
        idx_nx     = idx;
`endif
        if (!en) begin
            state_nx   = IDLE;
            d_nx       = '0;
            d_valid_nx = 1'b0;
            timer_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
`ifdef DECODER_SCAN_EN
                    if (mode) begin
                        state_nx   = SCAN;
                        idx_nx     = '0;
                        d_nx       = W'(1);
                        d_valid_nx = 1'b1;
                        timer_nx   = RELOAD;
                    end else
`endif
                    if (sel_valid) begin
                        state_nx   = HOLD;
                        d_nx       = W'(1) << sel;
                        d_valid_nx = 1'b1;
                        timer_nx   = RELOAD;
                    end
                end
                HOLD: begin
                    if (timer == 8'd0) begin
                        state_nx   = IDLE;
                        d_nx       = '0;
                        d_valid_nx = 1'b0;
                    end else begin
                        timer_nx = timer - 8'd1;
                    end
                end
                SCAN: begin
`ifdef DECODER_SCAN_EN
                    if (!mode) begin
                        state_nx   = IDLE;
                        d_nx       = '0;
                        d_valid_nx = 1'b0;
                        timer_nx   = '0;
                    end else if (timer == 8'd0) begin
                        // Index rolls over naturally in N bits; flag the top-to-zero step.
                        idx_nx   = idx + N'(1);
                        d_nx     = W'(1) << (idx + N'(1));
                        wrap_nx  = (idx == N'(W - 1));
                        timer_nx = RELOAD;
                    end else begin
                        timer_nx = timer - 8'd1;
                    end
`else
                    state_nx   = IDLE;
                    d_nx       = '0;
                    d_valid_nx = 1'b0;
                    timer_nx   = '0;
`endif
                end
                default: begin
                    state_nx   = IDLE;
                    d_nx       = '0;
                    d_valid_nx = 1'b0;
                    timer_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            D         <= '0;
            D_valid   <= 1'b0;
            scan_wrap <= 1'b0;
            timer     <= '0;
        end else begin
            state     <= state_nx;
            D         <= d_nx;
            D_valid   <= d_valid_nx;
            scan_wrap <= wrap_nx;
            timer     <= timer_nx;
        end
    end

`ifdef DECODER_SCAN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx <= '0;
        else     idx <= idx_nx;
    end
`endif

endmodule

// File: doc/decoder_nto2n_seq.md
DECODER_NTO2N_SEQ -- requirements
Module: decoder_nto2n_seq

Interface
REQ-001 Parameter N, default 2: select width; output width 2**N; legal range 1..6.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles each output code is held; legal range 1..255; 8-bit internal timer.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  block enable; low forces return to IDLE.
REQ-006 mode  input  1  0 = direct decode, 1 = scan (walk all outputs).
REQ-007 sel_valid  input  1  request present on sel.
REQ-008 sel  input  N  binary index to decode.
REQ-009 sel_ready  output  1  block accepts a request this cycle.
REQ-010 D  output  2**N  registered one-hot output; all-zero when idle.
REQ-011 D_valid  output  1  D holds a live code.
REQ-012 busy  output  1  state is not IDLE.
REQ-013 scan_wrap  output  1  one-cycle pulse when scan wraps from the top index to 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, HOLD and SCAN, all registered.
REQ-015 sel_ready SHALL be combinational: 1 only when state=IDLE, en=1 and mode=0.
REQ-016 Handshake: a request is accepted on the rising edge where sel_valid=1 and sel_ready=1.
REQ-017 On acceptance, D SHALL equal one-hot(sel) and D_valid SHALL be 1 from the next cycle (latency 1); the state moves to HOLD and the timer loads HOLD_CYCLES-1.
REQ-018 HOLD: the timer decrements each cycle; on the edge where it is 0, D and D_valid clear and the state returns to IDLE, so D is valid for exactly HOLD_CYCLES cycles.
REQ-019 sel and sel_valid SHALL be ignored outside IDLE; requests are never queued.
REQ-020 IDLE with en=1 and mode=1: next cycle state=SCAN, D=one-hot(0), D_valid=1, timer=HOLD_CYCLES-1.
REQ-021 SCAN: when the timer reaches 0, the index advances by 1 and the timer reloads; index 2**N-1 wraps to 0 with scan_wrap=1 for that one cycle.
REQ-022 SCAN with mode=0 sampled: next cycle D=0, D_valid=0, state=IDLE; a partial slot is abandoned.
REQ-023 Any state with en=0 sampled: next cycle D=0, D_valid=0, scan_wrap=0, timer=0, state=IDLE. en has priority over mode and the handshake.
REQ-024 IDLE with en=1, mode=0 and sel_valid=1 takes the direct path; mode=1 takes priority over sel_valid in IDLE.
REQ-025 D SHALL always be all-zero or exactly one-hot; D_valid=1 if and only if D is non-zero.
REQ-026 busy SHALL be 1 in HOLD and SCAN and 0 in IDLE.
REQ-027 With HOLD_CYCLES=1, each code lasts one cycle; in SCAN the index advances every cycle.

Reset
REQ-028 While rst=1, regardless of clk: state=IDLE, D=0, D_valid=0, busy=0, scan_wrap=0, timer=0, scan index=0.
REQ-029 Reset asserted mid-HOLD or mid-SCAN SHALL clear immediately, without a clock edge.
REQ-030 After rst deasserts, the first request SHALL be accepted on the first rising edge that meets REQ-016.

Configuration
REQ-031 Macro DECODER_SCAN_EN defined: scan mode is built as in REQ-020 to REQ-022.
REQ-032 Macro DECODER_SCAN_EN undefined: the SCAN state and scan index are not built; mode is ignored and treated as 0; scan_wrap is tied to 0; the port list is unchanged.

Verification (N=2, HOLD_CYCLES=4, DECODER_SCAN_EN defined unless stated)
REQ-033 Direct: sel=2 with sel_valid pulsed in IDLE -> next cycle D=4'b0100, D_valid=1 for 4 cycles, then D=0 and sel_ready=1.
REQ-034 Busy ignore: a new request sel=3 during HOLD -> ignored, D stays 4'b0100, sel_ready=0 until IDLE.
REQ-035 Scan: mode=1 held for 17 cycles -> D walks 0001, 0010, 0100, 1000 with 4 cycles each; scan_wrap pulses once on the return to 0001.
REQ-036 Abort: en=0 for one cycle mid-HOLD -> next cycle D=0, busy=0; and rst pulsed mid-SCAN -> D=0 asynchronously.
REQ-037 Build without DECODER_SCAN_EN: mode=1 with sel=1 -> direct decode D=4'b0010; scan_wrap never asserts.
REQ-038 Sweep N=1 and N=3 with HOLD_CYCLES=1: every sel value decodes to the correct single bit and lasts one cycle.
